// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// Holds the FSM state encoding, the default datapath width and the opcode values.
package alu_sched_pkg;

    localparam int unsigned WIDTH_DEF = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant that favours the requester
// that was not served last whenever both are requesting.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external multi-cycle ALU between two requesters, returning each
// result on a single response channel tagged with the owning requester id.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_select,
    output logic             alu_reset_n,
    input  logic [WIDTH-1:0] alu_f,
    output logic             busy
);

    state_t           r_state;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_id;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_data;

    logic [1:0]       w_grant;
    logic             w_idle;
    logic             w_exec;
    logic             w_accept;

    rr_arb2 u_arb (
        .req        ({req1_valid, req0_valid}),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    assign w_idle     = (r_state == ST_IDLE);
    assign w_exec     = (r_state == ST_EXEC);
    assign req0_ready = w_idle & w_grant[0];
    assign req1_ready = w_idle & w_grant[1];
    assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign alu_a       = w_exec ? r_a : '0;
    assign alu_b       = w_exec ? r_b : '0;
    assign alu_select  = w_exec ? r_op : 1'b0;
    assign alu_reset_n = w_exec;

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;
    assign busy      = ~w_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 1'b0;
            r_id         <= 1'b0;
            r_cnt        <= '0;
            r_data       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_grant[1] ? req1_a  : req0_a;
                        r_b     <= w_grant[1] ? req1_b  : req0_b;
                        r_op    <= w_grant[1] ? req1_op : req0_op;
                        r_id    <= w_grant[1];
                        r_cnt   <= 2'(ALU_LAT);
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Counter reaches zero on this edge, so alu_f is sampled
                    // at the end of the ALU_LAT-th EXEC cycle.
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_data  <= alu_f;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_last_grant <= r_id;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: two instances (ALU_LAT 1 and 3) driven by directed
// and random operations, checked against an arithmetic/round-robin model.
module tb_alu_scheduler;
    import alu_sched_pkg::*;

    localparam int unsigned W = WIDTH_DEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst, v0, v1, op0, op1, rrdy;
    logic [1:0][W-1:0] a0, b0, a1, b1;
    logic [1:0]        rdy0, rdy1, rv, rid, sel, arn, bsy;
    logic [1:0][W-1:0] rdata, aa, ab, f;

    int tests = 0;
    int fails = 0;
    bit exp_lg [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LATG = (g == 0) ? 1 : 3;
        int unsigned icnt = 0;
        logic [W-1:0] w_good;

        alu_scheduler #(.WIDTH(W), .ALU_LAT(LATG)) u_dut (
            .clk         (clk),
            .reset       (rst[g]),
            .req0_valid  (v0[g]),
            .req0_ready  (rdy0[g]),
            .req0_a      (a0[g]),
            .req0_b      (b0[g]),
            .req0_op     (op0[g]),
            .req1_valid  (v1[g]),
            .req1_ready  (rdy1[g]),
            .req1_a      (a1[g]),
            .req1_b      (b1[g]),
            .req1_op     (op1[g]),
            .rsp_valid   (rv[g]),
            .rsp_ready   (rrdy[g]),
            .rsp_id      (rid[g]),
            .rsp_data    (rdata[g]),
            .alu_a       (aa[g]),
            .alu_b       (ab[g]),
            .alu_select  (sel[g]),
            .alu_reset_n (arn[g]),
            .alu_f       (f[g]),
            .busy        (bsy[g])
        );

        // External ALU: output is only correct on the LATG-th cycle after issue.
        always @(posedge clk) icnt <= arn[g] ? icnt + 1 : 0;
        assign w_good = sel[g] ? W'(aa[g] - ab[g]) : W'(aa[g] + ab[g]);
        assign f[g]   = (arn[g] && icnt == LATG - 1) ? w_good : (w_good ^ 3'b101);
    end

    function automatic int lat_of(bit g);
        return g ? 3 : 1;
    endfunction

    task automatic chk(string tag, bit g, logic [7:0] obs, logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s [lat%0d]: got %0h expected %0h", tag, lat_of(g), obs, exp);
        end
    endtask

    task automatic do_reset(bit g);
        @(negedge clk);
        rst[g] = 1'b1; v0[g] = 1'b0; v1[g] = 1'b0; rrdy[g] = 1'b0;
        @(negedge clk);
        rst[g] = 1'b0;
        exp_lg[g] = 1'b1;
        #1;
        chk("rst_rsp_valid", g, 8'(rv[g]), 8'd0);
        chk("rst_rsp_id", g, 8'(rid[g]), 8'd0);
        chk("rst_rsp_data", g, 8'(rdata[g]), 8'd0);
        chk("rst_busy", g, 8'(bsy[g]), 8'd0);
        chk("rst_alu_reset_n", g, 8'(arn[g]), 8'd0);
    endtask

    // Starts at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic run_op(bit g, bit rv0, bit rv1, logic [2:0] xa0, logic [2:0] xb0, bit xop0,
                          logic [2:0] xa1, logic [2:0] xb1, bit xop1, int delay, bit hold,
                          output int gid);
        int ea, eb, er;
        bit eop;
        v0[g] = rv0; a0[g] = xa0; b0[g] = xb0; op0[g] = xop0;
        v1[g] = rv1; a1[g] = xa1; b1[g] = xb1; op1[g] = xop1;
        rrdy[g] = 1'($urandom_range(0, 1));
        if (rv0 && rv1)  gid = exp_lg[g] ? 0 : 1;
        else if (rv0)    gid = 0;
        else if (rv1)    gid = 1;
        else             gid = -1;
        #1;
        chk("idle_ready0", g, 8'(rdy0[g]), 8'(gid == 0));
        chk("idle_ready1", g, 8'(rdy1[g]), 8'(gid == 1));
        if (gid < 0) begin
            @(negedge clk);
            #1;
            chk("idle_busy", g, 8'(bsy[g]), 8'd0);
            chk("idle_rsp_valid", g, 8'(rv[g]), 8'd0);
            return;
        end
        ea  = (gid == 1) ? int'(xa1) : int'(xa0);
        eb  = (gid == 1) ? int'(xb1) : int'(xb0);
        eop = (gid == 1) ? xop1 : xop0;
        er  = eop ? ((ea - eb) % 8 + 8) % 8 : (ea + eb) % 8;
        @(negedge clk);
        // Scramble the request operands so only captured values can be correct.
        a0[g] = 3'($urandom); b0[g] = 3'($urandom); a1[g] = 3'($urandom); b1[g] = 3'($urandom);
        if (!hold) begin v0[g] = 1'b0; v1[g] = 1'b0; end
        for (int k = 0; k < lat_of(g); k++) begin
            rrdy[g] = 1'($urandom_range(0, 1));
            #1;
            chk("exec_rsp_valid", g, 8'(rv[g]), 8'd0);
            chk("exec_busy", g, 8'(bsy[g]), 8'd1);
            chk("exec_ready0", g, 8'(rdy0[g]), 8'd0);
            chk("exec_ready1", g, 8'(rdy1[g]), 8'd0);
            chk("exec_alu_reset_n", g, 8'(arn[g]), 8'd1);
            chk("exec_alu_a", g, 8'(aa[g]), 8'(ea));
            chk("exec_alu_b", g, 8'(ab[g]), 8'(eb));
            chk("exec_alu_select", g, 8'(sel[g]), 8'(eop));
            @(negedge clk);
        end
        for (int d = 0; d <= delay; d++) begin
            rrdy[g] = (d == delay);
            #1;
            chk("resp_rsp_valid", g, 8'(rv[g]), 8'd1);
            chk("resp_rsp_id", g, 8'(rid[g]), 8'(gid));
            chk("resp_rsp_data", g, 8'(rdata[g]), 8'(er));
            chk("resp_ready0", g, 8'(rdy0[g]), 8'd0);
            chk("resp_ready1", g, 8'(rdy1[g]), 8'd0);
            chk("resp_busy", g, 8'(bsy[g]), 8'd1);
            chk("resp_alu_reset_n", g, 8'(arn[g]), 8'd0);
            chk("resp_alu_a", g, 8'(aa[g]), 8'd0);
            @(negedge clk);
        end
        rrdy[g] = 1'b0;
        exp_lg[g] = (gid == 1);
        #1;
        chk("done_busy", g, 8'(bsy[g]), 8'd0);
        chk("done_rsp_valid", g, 8'(rv[g]), 8'd0);
    endtask

    task automatic abort_exec(bit g);
        v0[g] = 1'b1; a0[g] = 3'd5; b0[g] = 3'd1; op0[g] = OP_ADD; v1[g] = 1'b0;
        @(negedge clk);
        v0[g] = 1'b0;
        #1;
        chk("abort_in_exec", g, 8'(arn[g]), 8'd1);
        rst[g] = 1'b1;
        @(negedge clk);
        rst[g] = 1'b0;
        exp_lg[g] = 1'b1;
        #1;
        chk("abort_rsp_valid", g, 8'(rv[g]), 8'd0);
        chk("abort_alu_reset_n", g, 8'(arn[g]), 8'd0);
        chk("abort_busy", g, 8'(bsy[g]), 8'd0);
        for (int k = 0; k < 4; k++) begin
            rrdy[g] = 1'b1;
            @(negedge clk);
            #1;
            chk("abort_no_rsp", g, 8'(rv[g]), 8'd0);
        end
        rrdy[g] = 1'b0;
    endtask

    initial begin
        int gid;
        rst = '1; v0 = '0; v1 = '0; op0 = '0; op1 = '0; rrdy = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        for (int gi = 0; gi < 2; gi++) begin
            bit g;
            g = 1'(gi);
            do_reset(g);
            run_op(g, 1, 0, 3'd3, 3'd2, OP_ADD, 3'd0, 3'd0, OP_ADD, 0, 0, gid);
            run_op(g, 0, 1, 3'd0, 3'd0, OP_ADD, 3'd1, 3'd3, OP_SUB, 0, 0, gid);
            run_op(g, 1, 0, 3'd7, 3'd7, OP_ADD, 3'd0, 3'd0, OP_ADD, 0, 0, gid);
            do_reset(g);
            for (int k = 0; k < 4; k++)
                run_op(g, 1, 1, 3'(k), 3'(k + 2), OP_ADD, 3'(k + 5), 3'(k), OP_SUB, 0, 1, gid);
            run_op(g, 0, 1, 3'd2, 3'd2, OP_ADD, 3'd4, 3'd6, OP_SUB, 5, 0, gid);
            run_op(g, 0, 0, 3'd1, 3'd1, OP_ADD, 3'd1, 3'd1, OP_ADD, 0, 0, gid);
            abort_exec(g);
            for (int i = 0; i < 25; i++)
                run_op(g, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
                       3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), gid);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
